ram_bus: RTL
============

Name: ram_bus

Overview:
- Parametrised on-chip byte-addressed RAM with a valid/ready request/response handshake, per-byte write enables, configurable response latency and out-of-range error reporting.
- Successor to the current combinational-read word RAM; sits between the core's load/store unit (or instruction fetch) and on-chip memory.
- One transaction in flight; big-endian byte order within a word.

Parameters:
- XLEN, 32, data width in bits; multiple of 8; NB = XLEN/8 bytes per word.
- MEM_SIZE, 1024, memory size in bytes; power of two; at least NB.
- LATENCY, 1, cycles from request acceptance to rsp_valid_o; range 1..15.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  block can accept a request.
- req_we_i  in  1  1 = write, 0 = read.
- req_addr_i  in  XLEN  byte address; low log2(NB) bits ignored (word-aligned access).
- req_be_i  in  NB  byte enables; bit k covers data[8k+7:8k].
- req_data_i  in  XLEN  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer accepts response.
- rsp_data_o  out  XLEN  read data; 0 for writes and errors.
- rsp_err_o  out  1  address out of range.

Behaviour:
- Reset (rst_i=1 at edge): state=IDLE, req_ready_o=1, rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, latency counter=0. Memory contents not reset.
- Reset mid-transaction abandons it; no response is issued. A write accepted before reset stays committed.
- Addressing: word base = addr with low log2(NB) bits cleared.
- Big-endian lanes: lane k (data[8k+7:8k]) maps to mem[base + NB-1-k]. For XLEN=32, data[31:24] is at base+0.
- Out of range: any bit of req_addr_i at or above log2(MEM_SIZE) is nonzero. The transaction is accepted normally, but there is no write, rsp_data_o=0 and rsp_err_o=1.
- Handshake: a request is accepted on an edge where req_valid_i && req_ready_o. A response completes on an edge where rsp_valid_o && rsp_ready_i.
- req_ready_o=1 only in IDLE.
- Response fields are stable while rsp_valid_o=1 && !rsp_ready_i.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on accept:
  - Write: performed at that edge, only for lanes with be=1 and only if in range. Response data=0.
  - Read: the full word is sampled at that edge into the response register, regardless of be.
  - Err flag is captured.
  - Next state is RESP if LATENCY=1; otherwise WAIT with counter=LATENCY-1.
- WAIT: counter decrements each cycle; go to RESP when counter reaches 1 (decrement then compare). Net result: rsp_valid_o rises exactly LATENCY cycles after the accepting edge.
- RESP: rsp_valid_o=1. On rsp_ready_i go to IDLE; rsp_valid_o=0 and req_ready_o=1 in the following cycle. No request is accepted in the same cycle as response completion.
- Maximum throughput: one transaction per LATENCY+1 cycles when rsp_ready_i is held at 1.
- Write with be=0: legal no-op; a normal response is still returned.
- req_* inputs are ignored outside IDLE.
- Sampled read data is unaffected by later writes, since only one transaction is ever outstanding.

Test Plan:
- Reset then write addr=0x10, be=4'b1111, data=0xDEADBEEF; read 0x10 with LATENCY=1 -> rsp_valid_o 1 cycle after accept; rsp_data_o=0xDEADBEEF; mem[0x10]=0xDE, mem[0x13]=0xEF; err=0.
- Partial write 0x10, be=4'b0101, data=0x11223344; read 0x12 (aligned to 0x10) -> 0xDE22BE44.
- LATENCY=4: accept read at cycle t -> rsp_valid_o first high at t+4. Hold rsp_ready_i=0 for 3 cycles -> data stable, req_ready_o=0 throughout. Raise rsp_ready_i -> req_ready_o=1 next cycle.
- MEM_SIZE=1024: write 0x400, data 0xFFFFFFFF -> rsp_err_o=1, rsp_data_o=0. Read 0x000 afterwards -> unchanged.
- Assert rst_i during WAIT of a read (LATENCY=3) -> next cycle rsp_valid_o=0, req_ready_o=1; no response ever appears for the aborted read.
- XLEN=64, NB=8: write 0x0123456789ABCDEF to 0x8 -> mem[0x8]=0x01, mem[0xF]=0xEF; readback matches.

Source files
------------

// File: rtl/ram_bus.sv
// Byte-addressed on-chip RAM behind a valid/ready request/response handshake.
// Big-endian lanes, per-byte write enables, fixed response latency, range error.
module ram_bus #(
  parameter int XLEN     = 32,
  parameter int MEM_SIZE = 1024,
  parameter int LATENCY  = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN/8-1:0] req_be_i,
  input  logic [XLEN-1:0]   req_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic              rsp_err_o
);

  localparam int NB = XLEN / 8;
  localparam int AW = $clog2(MEM_SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            err_q, err_d;

  logic [7:0]      mem_q [MEM_SIZE];
  logic [AW-1:0]   base;
  logic            oor;
  logic            accept;
  logic [XLEN-1:0] rd_word;

  assign base   = req_addr_i[AW-1:0] & ~AW'(NB-1);
  assign oor    = (req_addr_i >> AW) != '0;
  // A request coinciding with reset is never accepted, so it cannot write.
  assign accept = req_valid_i && (state_q == IDLE) && !rst_i;

  // Base is word aligned, so OR-ing in the lane offset equals adding it.
  always_comb begin
    rd_word = '0;
    for (int k = 0; k < NB; k++) begin
      rd_word[8*k +: 8] = mem_q[base | AW'(NB-1-k)];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NB; k++) begin
      if (accept && req_we_i && !oor && req_be_i[k]) begin
        mem_q[base | AW'(NB-1-k)] <= req_data_i[8*k +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          err_d  = oor;
          data_d = (req_we_i || oor) ? '0 : rd_word;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        // Last waiting cycle: valid rises LATENCY cycles after the accept edge.
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_data_o  = data_q;
  assign rsp_err_o   = err_q;

endmodule
